// File: rtl/reg_file_sb_if.sv
// Bus bundle for the scoreboarded register file: two read ports with
// pending flags, one write port and one reserve port.
interface reg_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              rsv;
   logic [ADDR_W-1:0] rsv_a;
   logic              pend1;
   logic              pend2;
   logic              stall;

   modport master (
      output ra1, ra2, we, wa, wd, rsv, rsv_a,
      input  rd1, rd2, pend1, pend2, stall
   );

   modport slave (
      input  ra1, ra2, we, wa, wd, rsv, rsv_a,
      output rd1, rd2, pend1, pend2, stall
   );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a pending-write scoreboard. Register 0 is hardwired
// to zero and can never be reserved. Reads are combinational with
// write-through bypass; the scoreboard lets issue logic stall on operands
// whose producer has not written back yet.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   reg_file_sb_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_pend;

   logic [DEPTH-1:0]  w_wdec;
   logic [DEPTH-1:0]  w_rdec;
   logic [DEPTH-1:0]  w_pend_nxt;
   logic              w_wr_ok;
   logic              w_byp1;
   logic              w_byp2;

   // One-hot decode of write and reserve addresses; address 0 never decodes.
   always_comb begin
      w_wr_ok = bus.we && (bus.wa != '0);
      w_wdec  = '0;
      w_rdec  = '0;
      if (w_wr_ok) begin
         w_wdec = ONE_HOT0 << bus.wa;
      end
      if (bus.rsv && (bus.rsv_a != '0)) begin
         w_rdec = ONE_HOT0 << bus.rsv_a;
      end
      // Set after clear: a newer reservation owns the register even when an
      // older result lands on the same edge.
      w_pend_nxt = (r_pend & ~w_wdec) | w_rdec;
   end

   // Register storage; entry 0 only ever holds its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (w_wdec[i]) begin
               r_regs[i] <= bus.wd;
            end
         end
      end
   end

   // Pending scoreboard update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   // Combinational read with bypass; outputs forced low while in reset so
   // the bypass path cannot leak wd during reset.
   always_comb begin
      w_byp1    = w_wr_ok && (bus.ra1 == bus.wa);
      w_byp2    = w_wr_ok && (bus.ra2 == bus.wa);
      bus.rd1   = '0;
      bus.rd2   = '0;
      bus.pend1 = 1'b0;
      bus.pend2 = 1'b0;
      if (rst_n) begin
         bus.rd1   = w_byp1 ? bus.wd : r_regs[bus.ra1];
         bus.rd2   = w_byp2 ? bus.wd : r_regs[bus.ra2];
         bus.pend1 = r_pend[bus.ra1] && !w_byp1;
         bus.pend2 = r_pend[bus.ra2] && !w_byp2;
      end
      bus.stall = bus.pend1 || bus.pend2;
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. Stimulus sets up a cycle and pushes the
// expected read-port response; the monitor pops and compares on each
// falling clock edge.
module tb_reg_file_sb;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      string        name;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic         p1;
      logic         p2;
      logic         st;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input string fld,
                      input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, fld, act, req);
      end
   endtask

   // Monitor: compare every queued expectation against the live outputs.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.name, "rd1",   bus.rd1, e.rd1);
         cmp(e.name, "rd2",   bus.rd2, e.rd2);
         cmp(e.name, "pend1", {{(DW-1){1'b0}}, bus.pend1}, {{(DW-1){1'b0}}, e.p1});
         cmp(e.name, "pend2", {{(DW-1){1'b0}}, bus.pend2}, {{(DW-1){1'b0}}, e.p2});
         cmp(e.name, "stall", {{(DW-1){1'b0}}, bus.stall}, {{(DW-1){1'b0}}, e.st});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
      bus.rsv = 1'b0; bus.rsv_a = '0;
   endtask

   task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      bus.ra1 = a1; bus.ra2 = a2;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we = 1'b1; bus.wa = a; bus.wd = d;
   endtask

   task automatic rs(input logic [AW-1:0] a);
      bus.rsv = 1'b1; bus.rsv_a = a;
   endtask

   task automatic expect_o(input string name, input logic [DW-1:0] r1,
                           input logic [DW-1:0] r2, input logic p1,
                           input logic p2, input logic st);
      exp_t e;
      e.name = name; e.rd1 = r1; e.rd2 = r2; e.p1 = p1; e.p2 = p2; e.st = st;
      q.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      rd(5'd3, 5'd3);
      wr(5'd3, 32'hFF);
      rs(5'd3);
      #1;
      expect_o("in_reset_bypass", '0, '0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      idle();
      rd(5'd3, 5'd3);
      expect_o("reset_ignored_wr", '0, '0, 1'b0, 1'b0, 1'b0);
      step();

      rd(5'd5, 5'd31);
      expect_o("post_reset_read", '0, '0, 1'b0, 1'b0, 1'b0);
      step();

      wr(5'd0, 32'hDEADBEEF); rd(5'd0, 5'd0);
      expect_o("wr0_no_bypass", '0, '0, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      expect_o("wr0_discarded", '0, '0, 1'b0, 1'b0, 1'b0);
      step();

      wr(5'd7, 32'h12345678); rd(5'd7, 5'd0);
      expect_o("bypass7", 32'h12345678, '0, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      expect_o("stored7", 32'h12345678, '0, 1'b0, 1'b0, 1'b0);
      step();

      rs(5'd9); rd(5'd0, 5'd9);
      expect_o("rsv9_same_cycle", '0, '0, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      expect_o("pend9", '0, '0, 1'b0, 1'b1, 1'b1);
      step();
      wr(5'd9, 32'hA5);
      expect_o("wb9_bypass", '0, 32'hA5, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      expect_o("wb9_cleared", '0, 32'hA5, 1'b0, 1'b0, 1'b0);
      step();

      rs(5'd3); rd(5'd3, 5'd0);
      step();
      idle();
      expect_o("pend3", '0, '0, 1'b1, 1'b0, 1'b1);
      step();
      rs(5'd3); wr(5'd3, 32'h55);
      expect_o("set_clr_same_byp", 32'h55, '0, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      expect_o("set_wins", 32'h55, '0, 1'b1, 1'b0, 1'b1);
      step();

      rs(5'd10); wr(5'd3, 32'h66); rd(5'd10, 5'd7);
      expect_o("split_same_cycle", '0, 32'h12345678, 1'b0, 1'b0, 1'b0);
      step();
      idle(); rd(5'd10, 5'd3);
      expect_o("split_both_applied", '0, 32'h66, 1'b1, 1'b0, 1'b1);
      step();

      rs(5'd10);
      step();
      idle();
      expect_o("re_reserve", '0, 32'h66, 1'b1, 1'b0, 1'b1);
      step();
      wr(5'd10, 32'h1);
      step();
      idle();
      expect_o("re_reserve_single_clr", 32'h1, 32'h66, 1'b0, 1'b0, 1'b0);
      step();

      wr(5'd11, 32'hCAFE); rd(5'd0, 5'd0);
      step();
      idle(); rd(5'd11, 5'd0);
      expect_o("wr_not_pending", 32'hCAFE, '0, 1'b0, 1'b0, 1'b0);
      step();

      rs(5'd0);
      step();
      idle(); rd(5'd0, 5'd0);
      expect_o("rsv0_ignored", '0, '0, 1'b0, 1'b0, 1'b0);
      step();

      wr(5'd4, 32'h77); rs(5'd6);
      step();
      idle(); rd(5'd4, 5'd6);
      expect_o("pre_reset", 32'h77, '0, 1'b0, 1'b1, 1'b1);
      step();
      expect_o("async_reset", '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      step();
      expect_o("after_reset", '0, '0, 1'b0, 1'b0, 1'b0);
      step();
      rd(5'd7, 5'd9);
      expect_o("after_reset_regs", '0, '0, 1'b0, 1'b0, 1'b0);
      step();

      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         step();
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain actual=%0d pending required=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
